// File: rtl/noc_pkg.sv
// Shared port numbering, route encoding and XY routing rule for the mesh router node.
package noc_pkg;

    localparam int NPORT   = 5;
    localparam int PORT_PE = 0;
    localparam int PORT_N  = 1;
    localparam int PORT_S  = 2;
    localparam int PORT_E  = 3;
    localparam int PORT_W  = 4;

    // Route values R_PE..R_W share their numbering with the output port indices.
    typedef enum logic [2:0] {R_PE, R_N, R_S, R_E, R_W, R_DROP} route_e;

    // Columns are resolved before rows; anything outside the mesh is dropped.
    function automatic route_e xy_route(input int dc, input int dr,
                                        input int node_col, input int node_row,
                                        input int rows, input int cols);
        if (dc >= cols || dr >= rows) return R_DROP;
        if (dc > node_col)            return R_E;
        if (dc < node_col)            return R_W;
        if (dr > node_row)            return R_N;
        if (dr < node_row)            return R_S;
        return R_PE;
    endfunction

    function automatic int field_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mesh_router_sync_if.sv
// Five-port valid/ready bundle between a mesh router node and its surroundings.
interface mesh_router_sync_if #(parameter int WIDTH = 15);
    import noc_pkg::*;

    logic [NPORT-1:0]       in_valid;
    logic [NPORT*WIDTH-1:0] in_data;
    logic [NPORT-1:0]       in_ready;
    logic [NPORT-1:0]       out_valid;
    logic [NPORT*WIDTH-1:0] out_data;
    logic [NPORT-1:0]       out_ready;
    logic [7:0]             drop_cnt;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, drop_cnt);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, drop_cnt);
endinterface

// File: rtl/router_in_fifo.sv
// Circular-buffer input FIFO; full/empty come from the registered count only.
module router_in_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mesh_router_sync.sv
// Five-port XY mesh router node: per-input FIFOs, per-output round-robin, registered output slots.
module mesh_router_sync
    import noc_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 2,
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int NODE_ROW  = 0,
    parameter int NODE_COL  = 0,
    parameter int X_HOP_LOC = 4,
    parameter int Y_HOP_LOC = 7
) (
    input logic               clk,
    input logic               rst_n,
    mesh_router_sync_if.slave bus
);
    localparam int XW = field_w(COL);
    localparam int YW = field_w(ROW);

    logic [WIDTH-1:0]       head [NPORT];
    logic [NPORT-1:0]       empty, full, pop, load_en, grant_vld;
    logic [2:0]             grant_idx [NPORT];
    logic [2:0]             ptr [NPORT];
    route_e                 route [NPORT];
    logic [2:0]             n_drop;
    logic [8:0]             drop_sum;
    logic [NPORT-1:0]       out_valid_q;
    logic [NPORT*WIDTH-1:0] out_data_q;
    logic [7:0]             drop_cnt_q;

    for (genvar p = 0; p < NPORT; p++) begin : g_in
        router_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (bus.in_valid[p]),
            .push_data(bus.in_data[p*WIDTH +: WIDTH]),
            .pop      (pop[p]),
            .head     (head[p]),
            .empty    (empty[p]),
            .full     (full[p])
        );
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign load_en       = ~out_valid_q | bus.out_ready;
    assign drop_sum      = {1'b0, drop_cnt_q} + 9'(n_drop);

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            route[p] = xy_route(int'(head[p][X_HOP_LOC +: XW]), int'(head[p][Y_HOP_LOC +: YW]),
                                NODE_COL, NODE_ROW, ROW, COL);
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    always_comb begin
        int idx;
        idx       = 0;
        pop       = '0;
        n_drop    = '0;
        grant_vld = '0;
        for (int o = 0; o < NPORT; o++) grant_idx[o] = '0;

        for (int p = 0; p < NPORT; p++) begin
            if (!empty[p] && route[p] == R_DROP) begin
                pop[p] = 1'b1;
                n_drop = n_drop + 3'd1;
            end
        end

        // A head has exactly one route, so no input can win two outputs in one cycle.
        for (int o = 0; o < NPORT; o++) begin
            if (load_en[o]) begin
                for (int k = 0; k < NPORT; k++) begin
                    idx = (int'(ptr[o]) + k) % NPORT;
                    if (!grant_vld[o] && !empty[idx] && int'(route[idx]) == o) begin
                        grant_vld[o] = 1'b1;
                        grant_idx[o] = 3'(idx);
                        pop[idx]     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
            for (int o = 0; o < NPORT; o++) ptr[o] <= '0;
        end else begin
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            for (int o = 0; o < NPORT; o++) begin
                if (load_en[o]) begin
                    out_valid_q[o] <= grant_vld[o];
                    if (grant_vld[o]) begin
                        out_data_q[o*WIDTH +: WIDTH] <= head[grant_idx[o]];
                        ptr[o] <= (grant_idx[o] == 3'(NPORT - 1)) ? 3'd0 : grant_idx[o] + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_router_sync.sv
// Directed and randomized checks of mesh_router_sync against an XY-routing reference model.
module tb_mesh_router_sync;

    localparam int W = 15;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mesh_router_sync_if #(.WIDTH(W)) a_if ();
    mesh_router_sync_if #(.WIDTH(W)) b_if ();
    mesh_router_sync_if #(.WIDTH(W)) c_if ();

    // Interior node (1,2) of a 4x4 mesh.
    mesh_router_sync #(.WIDTH(W), .DEPTH(2), .ROW(4), .COL(4), .NODE_ROW(1), .NODE_COL(2),
                       .X_HOP_LOC(4), .Y_HOP_LOC(7))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

    // Node (3,3) with a 3-bit column field so that off-mesh columns 5..7 are expressible.
    mesh_router_sync #(.WIDTH(W), .DEPTH(2), .ROW(4), .COL(5), .NODE_ROW(3), .NODE_COL(3),
                       .X_HOP_LOC(4), .Y_HOP_LOC(7))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    // Corner node (0,0) of a 4x4 mesh.
    mesh_router_sync #(.WIDTH(W), .DEPTH(2), .ROW(4), .COL(4), .NODE_ROW(0), .NODE_COL(0),
                       .X_HOP_LOC(4), .Y_HOP_LOC(7))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference route for node (1,2), 4x4: returns the output port index.
    function automatic int ref_route_a(input logic [W-1:0] d);
        int dc, dr;
        dc = int'(d[5:4]);
        dr = int'(d[8:7]);
        if (dc > 2) return 3;
        if (dc < 2) return 4;
        if (dr > 1) return 1;
        if (dr < 1) return 2;
        return 0;
    endfunction

    logic [W-1:0] expq [25][$];
    int           seq [5];
    logic [4:0]   fired;
    logic [4:0]   seen;
    logic [W-1:0] d;
    int           acc, k, pend, qi, left;
    logic         fire, gen;

    initial begin
        rst_n = 1'b0;
        a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = '1;
        b_if.in_valid = '0; b_if.in_data = '0; b_if.out_ready = '1;
        c_if.in_valid = '0; c_if.in_data = '0; c_if.out_ready = '1;
        #12;
        check("rst_out_valid", a_if.out_valid, 5'b00000);
        check("rst_out_data", a_if.out_data, '0);
        check("rst_drop_cnt", b_if.drop_cnt, 8'd0);
        check("rst_in_ready", a_if.in_ready, 5'b11111);
        #10 rst_n = 1'b1;
        step();

        // PE -> E, uncontended latency
        a_if.in_data[0 +: W] = 15'h00B0;
        a_if.in_valid = 5'b00001;
        step();
        a_if.in_valid = '0;
        check("pe_e_early", a_if.out_valid, 5'b00000);
        step();
        check("pe_e_valid", a_if.out_valid, 5'b01000);
        check("pe_e_data", a_if.out_data[3*W +: W], 15'h00B0);
        step();
        check("pe_e_done", a_if.out_valid, 5'b00000);

        // N,S,E,W all to W at once: round robin from pointer 0
        for (int p = 1; p < 5; p++) a_if.in_data[p*W +: W] = 15'h0090 | 15'(p);
        a_if.in_valid = 5'b11110;
        step();
        a_if.in_valid = '0;
        for (int i = 1; i < 5; i++) begin
            step();
            check("rr_w_valid", a_if.out_valid, 5'b10000);
            check("rr_w_data", a_if.out_data[4*W +: W], 15'h0090 | 15'(i));
        end
        step();
        check("rr_w_idle", a_if.out_valid, 5'b00000);
        // Pointer back at 0: PE beats N
        a_if.in_data[0 +: W] = 15'h0090;
        a_if.in_data[1*W +: W] = 15'h0091;
        a_if.in_valid = 5'b00011;
        step();
        a_if.in_valid = '0;
        step();
        check("rr_ptr_first", a_if.out_data[4*W +: W], 15'h0090);
        step();
        check("rr_ptr_second", a_if.out_data[4*W +: W], 15'h0091);
        step();

        // Backpressure on PE output
        a_if.out_ready = 5'b11110;
        a_if.in_data[0 +: W] = 15'h0120;
        a_if.in_valid = 5'b00001;
        step();
        a_if.in_data[0 +: W] = 15'h00A0;
        step();
        check("bp_n_valid", a_if.out_valid, 5'b00010);
        check("bp_n_data", a_if.out_data[1*W +: W], 15'h0120);
        acc = 1;
        a_if.in_data[0 +: W] = 15'h00A1;
        for (int c = 0; c < 8; c++) begin
            fire = a_if.in_ready[0];
            step();
            if (fire) begin
                acc++;
                a_if.in_data[0 +: W] = 15'h00A0 | 15'(acc);
            end
        end
        check("bp_accepted", acc, 3);
        check("bp_in_ready", a_if.in_ready[0], 1'b0);
        check("bp_hold_valid", a_if.out_valid, 5'b00001);
        check("bp_hold_data", a_if.out_data[0 +: W], 15'h00A0);
        a_if.out_ready = '1;
        k = 0;
        for (int c = 0; c < 30 && k < 5; c++) begin
            if (a_if.out_valid[0]) begin
                check("bp_drain_data", a_if.out_data[0 +: W], 15'h00A0 | 15'(k));
                k++;
            end
            fire = a_if.in_valid[0] && a_if.in_ready[0];
            step();
            if (fire) begin
                acc++;
                if (acc < 5) a_if.in_data[0 +: W] = 15'h00A0 | 15'(acc);
                else a_if.in_valid = '0;
            end
        end
        check("bp_drain_count", k, 5);

        // Off-mesh drops at node (3,3), COL=5
        b_if.in_data[0 +: W] = 15'h0050;
        b_if.in_valid = 5'b00001;
        step();
        b_if.in_valid = '0;
        step();
        step();
        check("drop_one", b_if.drop_cnt, 8'd1);
        check("drop_no_out", b_if.out_valid, 5'b00000);
        b_if.in_data[0 +: W] = 15'h0050;
        b_if.in_data[2*W +: W] = 15'h0060;
        b_if.in_data[3*W +: W] = 15'h0070;
        b_if.in_data[4*W +: W] = 15'h0051;
        b_if.in_valid = 5'b11101;
        step();
        b_if.in_valid = '0;
        step();
        check("drop_multi", b_if.drop_cnt, 8'd5);
        check("drop_multi_no_out", b_if.out_valid, 5'b00000);
        b_if.in_data[0 +: W] = 15'h0050;
        for (int phase = 0; phase < 2; phase++) begin
            acc = 0;
            b_if.in_valid = 5'b00001;
            for (int c = 0; c < 1000 && acc < (phase == 0 ? 200 : 100); c++) begin
                fire = b_if.in_ready[0];
                step();
                if (fire) acc++;
            end
            b_if.in_valid = '0;
            step(); step(); step();
            check("drop_batch_accepted", acc, (phase == 0) ? 200 : 100);
            check("drop_batch_cnt", b_if.drop_cnt, (phase == 0) ? 8'd205 : 8'd255);
        end
        repeat (5) step();
        check("drop_saturate_hold", b_if.drop_cnt, 8'd255);

        // Async reset with flits in flight
        a_if.out_ready = 5'b10111;
        a_if.in_data[0 +: W] = 15'h00B0;
        a_if.in_valid = 5'b00001;
        step();
        a_if.in_data[0 +: W] = 15'h00B1;
        step();
        a_if.in_valid = '0;
        check("rst_mid_before", a_if.out_valid, 5'b01000);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", a_if.out_valid, 5'b00000);
        check("rst_mid_data", a_if.out_data, '0);
        check("rst_mid_drop", b_if.drop_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_if.out_ready = '1;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen |= a_if.out_valid;
        end
        check("rst_no_stale", seen, 5'b00000);
        check("rst_ready_back", a_if.in_ready, 5'b11111);

        // Corner node (0,0): local delivery
        c_if.in_data[0 +: W] = 15'h0005;
        c_if.in_valid = 5'b00001;
        step();
        c_if.in_valid = '0;
        check("c_pe_early", c_if.out_valid, 5'b00000);
        step();
        check("c_pe_valid", c_if.out_valid, 5'b00001);
        check("c_pe_data", c_if.out_data[0 +: W], 15'h0005);

        // Randomized traffic on node (1,2) vs per-(input,output) queues
        step();
        fired = '0;
        for (int p = 0; p < 5; p++) seq[p] = 0;
        for (int cyc = 0; cyc < 1400; cyc++) begin
            gen = (cyc < 800);
            for (int p = 0; p < 5; p++) begin
                if (!a_if.in_valid[p] || fired[p]) begin
                    if (gen && $urandom_range(0, 1) == 1) begin
                        d = {6'(seq[p]), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                             2'($urandom_range(0, 3)), 1'b0, 3'(p)};
                        seq[p]++;
                        a_if.in_data[p*W +: W] = d;
                        a_if.in_valid[p] = 1'b1;
                    end else begin
                        a_if.in_valid[p] = 1'b0;
                    end
                end
            end
            a_if.out_ready = gen ? 5'($urandom) : 5'b11111;
            for (int o = 0; o < 5; o++) begin
                if (a_if.out_valid[o] && a_if.out_ready[o]) begin
                    d = a_if.out_data[o*W +: W];
                    qi = (int'(d[2:0]) < 5) ? int'(d[2:0]) * 5 + o : -1;
                    pend = (qi >= 0) ? expq[qi].size() : 0;
                    check("rand_pending", pend != 0, 1'b1);
                    if (pend != 0) check("rand_data", d, expq[qi].pop_front());
                end
            end
            for (int p = 0; p < 5; p++) begin
                fired[p] = a_if.in_valid[p] && a_if.in_ready[p];
                if (fired[p]) begin
                    d = a_if.in_data[p*W +: W];
                    expq[p*5 + ref_route_a(d)].push_back(d);
                end
            end
            step();
            left = 0;
            for (int q = 0; q < 25; q++) left += expq[q].size();
            if (!gen && left == 0 && a_if.in_valid == '0 && a_if.out_valid == '0) break;
        end
        left = 0;
        for (int q = 0; q < 25; q++) left += expq[q].size();
        check("rand_leftover", left, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
